// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Purpose  : Synchronise, debounce and edge-detect push buttons. Each event
//             sets a sticky pending flag that a slow consumer clears with
//             evt_ack. Optional auto-repeat is built when AUTO_REPEAT_EN is
//             defined.
//  Revision : 1.0  initial release
// ============================================================================

module button_conditioner #(
    parameter int N_BTN          = 4,
    parameter int DB_CYCLES      = 500000,
    parameter int REPEAT_DELAY   = 25000000,
    parameter int REPEAT_PERIOD  = 5000000,
    parameter int BTN_ACTIVE_LOW = 0
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] evt_ack,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] evt_pend,
    output logic [N_BTN-1:0] evt_overrun
);

    localparam int               CNT_W     = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic             C_INVERT  = (BTN_ACTIVE_LOW != 0);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_REL_DB   = 2'd3;

`ifdef AUTO_REPEAT_EN
    localparam int                HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int                HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] C_DELAY  = HOLD_W'(REPEAT_DELAY);
    localparam logic [HOLD_W-1:0] C_PERIOD = HOLD_W'(REPEAT_PERIOD);
`endif

    generate
        if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_cfg_invalid
            $error("button_conditioner: timing parameters out of range");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic [1:0]       sync_q,  sync_d;
            logic [CNT_W-1:0] cnt_q,   cnt_d;
            logic [1:0]       state_q, state_d;
            logic             level_q, level_d;
            logic             press_q, press_d;
            logic             pend_q,  pend_d;
            logic             ovr_q,   ovr_d;
            logic             w_synced;
            logic             w_differ;
            logic             w_flip;
            logic             w_rise;
            logic             w_repeat;

            // Debounce counter and press/release state tracking
            always_comb begin
                sync_d   = {sync_q[0], btn_raw[gi]};
                w_synced = sync_q[1] ^ C_INVERT;
                w_differ = (w_synced != level_q);
                w_flip   = w_differ && (cnt_q == C_DB_LAST);
                w_rise   = w_flip && !level_q;
                cnt_d    = (w_differ && !w_flip) ? cnt_q + 1'b1 : '0;
                level_d  = level_q ^ w_flip;

                state_d = state_q;
                case (state_q)
                    ST_IDLE: begin
                        if (w_differ) state_d = ST_PRESS_DB;
                    end
                    ST_PRESS_DB: begin
                        if (!w_differ)  state_d = ST_IDLE;
                        else if (w_flip) state_d = ST_HELD;
                    end
                    ST_HELD: begin
                        if (w_differ) state_d = ST_REL_DB;
                    end
                    ST_REL_DB: begin
                        if (!w_differ)  state_d = ST_HELD;
                        else if (w_flip) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

`ifdef AUTO_REPEAT_EN
            logic [HOLD_W-1:0] hold_q, hold_d;
            logic [HOLD_W-1:0] w_hold_inc;
            logic              rep_q, rep_d;
            logic              w_counting;

            // Hold counter runs up to the delay once, then to the period repeatedly
            always_comb begin
                w_counting = (state_q == ST_HELD) && !w_differ;
                w_hold_inc = hold_q + 1'b1;
                w_repeat   = w_counting && (w_hold_inc == (rep_q ? C_PERIOD : C_DELAY));
                hold_d     = hold_q;
                rep_d      = rep_q;
                if (w_rise) begin
                    hold_d = '0;
                    rep_d  = 1'b0;
                end else if (w_repeat) begin
                    hold_d = '0;
                    rep_d  = 1'b1;
                end else if (w_counting) begin
                    hold_d = w_hold_inc;
                end
            end

            always_ff @(posedge CLK or negedge reset) begin
                if (!reset) begin
                    hold_q <= '0;
                    rep_q  <= 1'b0;
                end else begin
                    hold_q <= hold_d;
                    rep_q  <= rep_d;
                end
            end
`else
            assign w_repeat = 1'b0;
`endif

            // A fresh event outranks an ack arriving in the same cycle
            always_comb begin
                press_d = w_rise | w_repeat;
                pend_d  = press_q ? 1'b1 : (evt_ack[gi] ? 1'b0 : pend_q);
                ovr_d   = ovr_q | (press_q & pend_q);
            end

            always_ff @(posedge CLK or negedge reset) begin
                if (!reset) begin
                    sync_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                    level_q <= 1'b0;
                    press_q <= 1'b0;
                    pend_q  <= 1'b0;
                    ovr_q   <= 1'b0;
                end else begin
                    sync_q  <= sync_d;
                    cnt_q   <= cnt_d;
                    state_q <= state_d;
                    level_q <= level_d;
                    press_q <= press_d;
                    pend_q  <= pend_d;
                    ovr_q   <= ovr_d;
                end
            end

            assign btn_level[gi]   = level_q;
            assign btn_press[gi]   = press_q;
            assign evt_pend[gi]    = pend_q;
            assign evt_overrun[gi] = ovr_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Purpose  : Directed self-checking bench for button_conditioner
//             (DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=4).
//  Revision : 1.0  initial release
// ============================================================================

module tb_button_conditioner;

    logic       CLK;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] evt_ack;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] evt_pend;
    logic [3:0] evt_overrun;

    int n_checks;
    int n_fail;

    button_conditioner #(
        .N_BTN          (4),
        .DB_CYCLES      (4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .BTN_ACTIVE_LOW (0)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .evt_ack     (evt_ack),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .evt_pend    (evt_pend),
        .evt_overrun (evt_overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        btn_raw = 4'b0;
        evt_ack = 4'b0;
        repeat (3) tick();
        n_checks++; if (btn_level !== 4'b0)   begin n_fail++; $display("FAIL reset.level: got %b expected 0000", btn_level); end
        n_checks++; if (btn_press !== 4'b0)   begin n_fail++; $display("FAIL reset.press: got %b expected 0000", btn_press); end
        n_checks++; if (evt_pend !== 4'b0)    begin n_fail++; $display("FAIL reset.pend: got %b expected 0000", evt_pend); end
        n_checks++; if (evt_overrun !== 4'b0) begin n_fail++; $display("FAIL reset.overrun: got %b expected 0000", evt_overrun); end
        reset = 1'b1;
        repeat (2) tick();
        n_checks++; if (btn_level !== 4'b0) begin n_fail++; $display("FAIL reset.idle_level: got %b expected 0000", btn_level); end
    endtask

    // btn 0: level and press at cycle 6, pending from cycle 7
    task automatic test_clean_press();
        logic exp_p, exp_l, exp_e;
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp_p = (k == 6);
            exp_l = (k >= 6);
            exp_e = (k >= 7);
            n_checks++; if (btn_press[0] !== exp_p) begin n_fail++; $display("FAIL clean.press k=%0d: got %b expected %b", k, btn_press[0], exp_p); end
            n_checks++; if (btn_level[0] !== exp_l) begin n_fail++; $display("FAIL clean.level k=%0d: got %b expected %b", k, btn_level[0], exp_l); end
            n_checks++; if (evt_pend[0] !== exp_e)  begin n_fail++; $display("FAIL clean.pend k=%0d: got %b expected %b", k, evt_pend[0], exp_e); end
        end
    endtask

    // Continues from test_clean_press at cycle 8 with btn 0 held
    task automatic test_release_bounce();
        logic exp_l;
        btn_raw[0] = 1'b0;
        for (int k = 9; k <= 15; k++) begin
            if (k == 11) btn_raw[0] = 1'b1;
            tick();
            n_checks++; if (btn_level[0] !== 1'b1) begin n_fail++; $display("FAIL relbounce.level k=%0d: got %b expected 1", k, btn_level[0]); end
            n_checks++; if (btn_press[0] !== 1'b0) begin n_fail++; $display("FAIL relbounce.press k=%0d: got %b expected 0", k, btn_press[0]); end
        end
        btn_raw[0] = 1'b0;
        for (int k = 16; k <= 21; k++) begin
            tick();
            exp_l = (k < 21);
            n_checks++; if (btn_level[0] !== exp_l) begin n_fail++; $display("FAIL release.level k=%0d: got %b expected %b", k, btn_level[0], exp_l); end
            n_checks++; if (btn_press[0] !== 1'b0)  begin n_fail++; $display("FAIL release.press k=%0d: got %b expected 0", k, btn_press[0]); end
        end
        evt_ack[0] = 1'b1;
        tick();
        evt_ack[0] = 1'b0;
        n_checks++; if (evt_pend[0] !== 1'b0) begin n_fail++; $display("FAIL ack.pend0: got %b expected 0", evt_pend[0]); end
    endtask

    task automatic test_bounce();
        int pulses;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                btn_raw[1] = (c < 3);
                tick();
                n_checks++; if (btn_level[1] !== 1'b0) begin n_fail++; $display("FAIL bounce.level r=%0d c=%0d: got %b expected 0", r, c, btn_level[1]); end
                n_checks++; if (btn_press[1] !== 1'b0) begin n_fail++; $display("FAIL bounce.press r=%0d c=%0d: got %b expected 0", r, c, btn_press[1]); end
            end
        end
        btn_raw[1] = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (btn_press[1] === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 1)          begin n_fail++; $display("FAIL bounce.final_pulses: got %0d expected 1", pulses); end
        n_checks++; if (btn_level[1] !== 1'b1) begin n_fail++; $display("FAIL bounce.final_level: got %b expected 1", btn_level[1]); end
        btn_raw[1] = 1'b0;
        repeat (8) tick();
        n_checks++; if (btn_level[1] !== 1'b0) begin n_fail++; $display("FAIL bounce.release_level: got %b expected 0", btn_level[1]); end
        evt_ack[1] = 1'b1;
        tick();
        evt_ack[1] = 1'b0;
        n_checks++; if (evt_pend[1] !== 1'b0) begin n_fail++; $display("FAIL bounce.ack_pend: got %b expected 0", evt_pend[1]); end
    endtask

    task automatic test_ack_race();
        btn_raw[2] = 1'b1;
        repeat (6) tick();
        n_checks++; if (btn_press[2] !== 1'b1) begin n_fail++; $display("FAIL race.press: got %b expected 1", btn_press[2]); end
        evt_ack[2] = 1'b1;
        tick();
        evt_ack[2] = 1'b0;
        n_checks++; if (evt_pend[2] !== 1'b1)    begin n_fail++; $display("FAIL race.pend: got %b expected 1", evt_pend[2]); end
        n_checks++; if (evt_overrun[2] !== 1'b0) begin n_fail++; $display("FAIL race.no_overrun: got %b expected 0", evt_overrun[2]); end
        btn_raw[2] = 1'b0;
        repeat (8) tick();
        n_checks++; if (btn_level[2] !== 1'b0) begin n_fail++; $display("FAIL race.release: got %b expected 0", btn_level[2]); end
        btn_raw[2] = 1'b1;
        repeat (6) tick();
        n_checks++; if (btn_press[2] !== 1'b1) begin n_fail++; $display("FAIL race.press2: got %b expected 1", btn_press[2]); end
        tick();
        n_checks++; if (evt_overrun[2] !== 1'b1) begin n_fail++; $display("FAIL race.overrun: got %b expected 1", evt_overrun[2]); end
        n_checks++; if (evt_pend[2] !== 1'b1)    begin n_fail++; $display("FAIL race.pend2: got %b expected 1", evt_pend[2]); end
        btn_raw[2] = 1'b0;
        evt_ack[2] = 1'b1;
        tick();
        evt_ack[2] = 1'b0;
        n_checks++; if (evt_pend[2] !== 1'b0)    begin n_fail++; $display("FAIL race.ack_clear: got %b expected 0", evt_pend[2]); end
        n_checks++; if (evt_overrun[2] !== 1'b1) begin n_fail++; $display("FAIL race.overrun_sticky: got %b expected 1", evt_overrun[2]); end
        repeat (8) tick();
    endtask

    // btn 3 press lands at cycle 6; k counts cycles after that press
    task automatic test_auto_repeat();
        logic exp_p;
        logic exp_o;
        int   k;
        btn_raw[3] = 1'b1;
        for (int j = 1; j <= 36; j++) begin
            tick();
            k = j - 6;
            if (k < 0) begin
                exp_p = 1'b0;
            end else begin
`ifdef AUTO_REPEAT_EN
                exp_p = (k == 0) || (k >= 10 && ((k - 10) % 3) == 0);
`else
                exp_p = (k == 0);
`endif
            end
            n_checks++; if (btn_press[3] !== exp_p) begin n_fail++; $display("FAIL repeat.press k=%0d: got %b expected %b", k, btn_press[3], exp_p); end
        end
`ifdef AUTO_REPEAT_EN
        exp_o = 1'b1;
`else
        exp_o = 1'b0;
`endif
        n_checks++; if (evt_overrun[3] !== exp_o) begin n_fail++; $display("FAIL repeat.overrun: got %b expected %b", evt_overrun[3], exp_o); end
        n_checks++; if (evt_pend[3] !== 1'b1)     begin n_fail++; $display("FAIL repeat.pend: got %b expected 1", evt_pend[3]); end
        btn_raw[3] = 1'b0;
        repeat (8) tick();
        n_checks++; if (btn_level[3] !== 1'b0) begin n_fail++; $display("FAIL repeat.release: got %b expected 0", btn_level[3]); end
    endtask

    task automatic test_async_reset();
        logic exp_v;
        btn_raw[1] = 1'b1;
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (btn_level !== 4'b0)   begin n_fail++; $display("FAIL areset.level: got %b expected 0000", btn_level); end
        n_checks++; if (btn_press !== 4'b0)   begin n_fail++; $display("FAIL areset.press: got %b expected 0000", btn_press); end
        n_checks++; if (evt_pend !== 4'b0)    begin n_fail++; $display("FAIL areset.pend: got %b expected 0000", evt_pend); end
        n_checks++; if (evt_overrun !== 4'b0) begin n_fail++; $display("FAIL areset.overrun: got %b expected 0000", evt_overrun); end
        tick();
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_v = (k == 6);
            n_checks++; if (btn_level[1] !== exp_v) begin n_fail++; $display("FAIL areset.relevel k=%0d: got %b expected %b", k, btn_level[1], exp_v); end
            n_checks++; if (btn_press[1] !== exp_v) begin n_fail++; $display("FAIL areset.repress k=%0d: got %b expected %b", k, btn_press[1], exp_v); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        btn_raw  = 4'b0;
        evt_ack  = 4'b0;
        test_reset();
        test_clean_press();
        test_release_bounce();
        test_bounce();
        test_ack_race();
        test_auto_repeat();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
